// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready link between pipeline stages
//
// Purpose: carries one pipeline entry (instruction word, PC, LANES payload
// words) together with its valid/ready handshake.
// Ports (modports):
//   master : drives valid, ir, pc, data; receives ready
//   slave  : receives valid, ir, pc, data; drives ready
interface pipe_stage_skid_if #(
  parameter int LANES = 5,
  parameter int W     = 32
);
  logic               valid;
  logic               ready;
  logic [W-1:0]       ir;
  logic [W-1:0]       pc;
  logic [LANES*W-1:0] data;

  modport master (output valid, output ir, output pc, output data, input ready);
  modport slave  (input valid, input ir, input pc, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - flushable pipeline stage register with one-entry skid buffer
//
// Purpose: registers one pipeline entry per cycle between two stages with a
// valid/ready handshake. A skid entry absorbs the one entry that arrives
// while downstream stalls, so in_ready never depends on out_ready.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   flush        in   discard all held entries
//   in_if        slave  upstream entry (valid/ready/ir/pc/data)
//   out_if       master presented entry; ir is NOP_IR when empty
//   occupancy    out  held entries 0..2
//   stall_cycles out  saturating count of cycles with out valid and not ready
module pipe_stage_skid #(
  parameter int           LANES    = 5,
  parameter int           W        = 32,
  parameter logic [W-1:0] NOP_IR   = 32'h0000_0000,
  parameter logic [W-1:0] RESET_PC = 32'h0000_3000,
  parameter int           CW       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_stage_skid_if.slave        in_if,
  pipe_stage_skid_if.master       out_if,
  output logic [1:0]              occupancy,
  output logic [CW-1:0]           stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       main_ir_q, main_ir_d;
  logic [W-1:0]       main_pc_q, main_pc_d;
  logic [LANES*W-1:0] main_data_q, main_data_d;
  logic [W-1:0]       skid_ir_q, skid_ir_d;
  logic [W-1:0]       skid_pc_q, skid_pc_d;
  logic [LANES*W-1:0] skid_data_q, skid_data_d;
  logic [CW-1:0]      stall_q, stall_d;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;

  // Ready comes from registered state only; downstream ready never reaches
  // the upstream side combinationally.
  assign in_ready  = (state_q != TWO) && !flush;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_if.valid && in_ready;
  assign out_fire  = out_valid && out_if.ready;

  assign in_if.ready   = in_ready;
  assign out_if.valid  = out_valid;
  assign out_if.ir     = out_valid ? main_ir_q : NOP_IR;
  // PC and payload keep the last main contents when empty.
  assign out_if.pc     = main_pc_q;
  assign out_if.data   = main_data_q;
  assign occupancy     = state_q;
  assign stall_cycles  = stall_q;

  always_comb begin
    state_d     = state_q;
    main_ir_d   = main_ir_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_ir_d   = skid_ir_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Main data is kept for out_pc/out_data; the skid entry is simply
      // forgotten by leaving the state empty.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_ir_d   = in_if.ir;
            main_pc_d   = in_if.pc;
            main_data_d = in_if.data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ir_d   = in_if.ir;
            main_pc_d   = in_if.pc;
            main_data_d = in_if.data;
          end else if (in_fire) begin
            state_d     = TWO;
            skid_ir_d   = in_if.ir;
            skid_pc_d   = in_if.pc;
            skid_data_d = in_if.data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d     = ONE;
            main_ir_d   = skid_ir_q;
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_if.ready && (stall_q != {CW{1'b1}})) begin
      stall_d = stall_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_ir_q   <= NOP_IR;
      main_pc_q   <= RESET_PC;
      main_data_q <= '0;
      skid_ir_q   <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_ir_q   <= main_ir_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_ir_q   <= skid_ir_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
  localparam int           LANES  = 5;
  localparam int           W      = 32;
  localparam int           DW     = LANES * W;
  localparam int           CW     = 4;
  localparam logic [W-1:0] NOP    = 32'h0000_0000;
  localparam logic [W-1:0] RST_PC = 32'h0000_3000;

  typedef struct packed {
    logic [W-1:0]  ir;
    logic [W-1:0]  pc;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;

  pipe_stage_skid_if #(.LANES(LANES), .W(W)) in_if ();
  pipe_stage_skid_if #(.LANES(LANES), .W(W)) out_if ();

  pipe_stage_skid #(
    .LANES(LANES), .W(W), .NOP_IR(NOP), .RESET_PC(RST_PC), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_if(in_if), .out_if(out_if),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   delivered = 0;
  int   d0;
  int   nxt;
  logic fired;
  ent_t cur;
  ent_t sb[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input int i);
    ent_t e;
    e.ir = W'(i);
    e.pc = 32'h1000 + W'(i * 4);
    for (int k = 0; k < LANES; k++) e.data[k*W +: W] = W'((i << 8) | (k + 1));
    return e;
  endfunction

  // Drive inputs just after the falling edge, then let them settle.
  task automatic drive(input logic v, input ent_t e, input logic rdy, input logic fl);
    cur          = e;
    in_if.valid  = v;
    in_if.ir     = e.ir;
    in_if.pc     = e.pc;
    in_if.data   = e.data;
    out_if.ready = rdy;
    flush        = fl;
    #1;
  endtask

  // Score this cycle's handshakes, then advance to the next falling edge.
  task automatic step(output logic f);
    ent_t e;
    f = 1'b0;
    if (reset) begin
      sb.delete();
    end else begin
      if (!out_if.valid) chk("nop_when_empty", out_if.ir, NOP);
      if (out_if.valid && out_if.ready) begin
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_ir", out_if.ir, e.ir);
          chk("out_pc", out_if.pc, e.pc);
          chk("out_data", out_if.data, e.data);
          delivered++;
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_if.valid && in_if.ready) begin
        sb.push_back(cur);
        f = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    drive(1'b0, mk(0), 1'b0, 1'b0);
    step(fired);
    step(fired);
    reset = 1'b0;
    drive(1'b0, mk(0), 1'b0, 1'b0);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_out_ir", out_if.ir, NOP);
    chk("rst_out_pc", out_if.pc, RST_PC);
    chk("rst_out_data", out_if.data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_in_ready", in_if.ready, 1);

    // Streaming at full rate: one-cycle latency, occupancy stays at 1.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, mk(i), 1'b1, 1'b0);
      if (i > 1) begin
        chk("stream_latency", out_if.ir, DW'(i - 1));
        chk("stream_occ", occupancy, 1);
      end
      step(fired);
    end
    drive(1'b0, mk(0), 1'b1, 1'b0);
    chk("stream_last", out_if.ir, 5);
    step(fired);
    chk("stream_drained_occ", occupancy, 0);
    chk("stream_stall", stall_cycles, 0);
    chk("stream_delivered", delivered, 5);

    // Backpressure: downstream stalls in cycles 3..6 while 8 entries stream.
    delivered = 0;
    nxt = 1;
    for (int c = 1; c <= 40 && delivered < 8; c++) begin
      drive(nxt <= 8, mk(16 + nxt), !(c >= 3 && c <= 6), 1'b0);
      if (c >= 4 && c <= 6) begin
        chk("bp_in_ready_low", in_if.ready, 0);
        chk("bp_occ_two", occupancy, 2);
      end
      step(fired);
      if (fired) nxt++;
    end
    chk("bp_delivered", delivered, 8);
    chk("bp_stall", stall_cycles, 4);
    chk("bp_sb_empty", sb.size(), 0);

    // Flush in TWO: the skid entry must never appear.
    drive(1'b1, mk(49), 1'b0, 1'b0);
    step(fired);
    drive(1'b1, mk(50), 1'b0, 1'b0);
    step(fired);
    chk("fl2_occ_before", occupancy, 2);
    drive(1'b0, mk(0), 1'b0, 1'b1);
    step(fired);
    drive(1'b0, mk(0), 1'b0, 1'b0);
    chk("fl2_out_valid", out_if.valid, 0);
    chk("fl2_out_ir", out_if.ir, NOP);
    chk("fl2_occ", occupancy, 0);
    chk("fl2_in_ready", in_if.ready, 1);
    chk("fl2_pc_retained", out_if.pc, mk(49).pc);
    d0 = delivered;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, mk(0), 1'b1, 1'b0);
      step(fired);
    end
    chk("fl2_nothing_delivered", delivered, d0);

    // Flush with in_valid and out_fire together.
    drive(1'b1, mk(65), 1'b1, 1'b0);
    step(fired);
    drive(1'b1, mk(66), 1'b1, 1'b1);
    chk("fl1_in_ready", in_if.ready, 0);
    chk("fl1_out_valid", out_if.valid, 1);
    d0 = delivered;
    step(fired);
    chk("fl1_consumed", delivered, d0 + 1);
    drive(1'b0, mk(0), 1'b1, 1'b0);
    chk("fl1_occ", occupancy, 0);
    chk("fl1_out_valid_after", out_if.valid, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, mk(0), 1'b1, 1'b0);
      step(fired);
    end
    chk("fl1_not_captured", delivered, d0 + 1);

    // Reset while holding two entries under a stall.
    drive(1'b1, mk(81), 1'b0, 1'b0);
    step(fired);
    drive(1'b1, mk(82), 1'b0, 1'b0);
    step(fired);
    chk("rs_occ_before", occupancy, 2);
    reset = 1'b1;
    drive(1'b1, mk(83), 1'b0, 1'b0);
    step(fired);
    reset = 1'b0;
    drive(1'b0, mk(0), 1'b0, 1'b0);
    chk("rs_out_pc", out_if.pc, RST_PC);
    chk("rs_out_data", out_if.data, 0);
    chk("rs_stall", stall_cycles, 0);
    chk("rs_occ", occupancy, 0);
    chk("rs_out_valid", out_if.valid, 0);
    chk("rs_in_ready", in_if.ready, 1);

    // Stall counter saturation at 2^CW-1.
    drive(1'b1, mk(97), 1'b0, 1'b0);
    step(fired);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, mk(0), 1'b0, 1'b0);
      step(fired);
    end
    chk("sat_stall_15", stall_cycles, 15);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, mk(0), 1'b0, 1'b0);
      step(fired);
    end
    chk("sat_stall_hold", stall_cycles, 15);
    d0 = delivered;
    drive(1'b0, mk(0), 1'b1, 1'b0);
    step(fired);
    chk("sat_drain", delivered, d0 + 1);
    chk("sat_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, flushable pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It is the successor of the fixed MEM/WB latch and can be instantiated at any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an instruction word, a PC and LANES payload words, supports backpressure without a combinational ready path from downstream, and presents a NOP instruction whenever no valid entry is held.

## Interface
- LANES, 5: number of payload words carried, e.g. PC4, PC8, AO, MDO, DR.
- W, 32: width of each payload word, IR and PC.
- NOP_IR, 32'h0000_0000: instruction presented on out_ir when the stage is empty.
- RESET_PC, 32'h0000_3000: out_pc value after reset.
- CW, 16: stall counter width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries (branch mispredict, exception).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ir  in  W  instruction word.
- in_pc  in  W  instruction PC.
- in_data  in  LANES*W  payload; lane k occupies bits [k*W +: W].
- out_valid  out  1  out_* holds a valid entry.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_ir  out  W  instruction word; NOP_IR when out_valid=0.
- out_pc  out  W  PC of the presented entry.
- out_data  out  LANES*W  payload of the presented entry.
- occupancy  out  2  held entries: 0, 1 or 2.
- stall_cycles  out  CW  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: a main entry (drives out_*) and a skid entry, each holding IR, PC and LANES words.
- State register: EMPTY, ONE (main only) or TWO (main and skid). occupancy encodes the state as 0, 1 or 2. out_valid = (state != EMPTY).
- in_ready = (state != TWO) & ~flush. It depends only on the state register and flush, never on out_ready.
- Transitions when flush=0:
  - EMPTY, in_fire -> ONE; main <= in.
  - ONE, in_fire & out_fire -> ONE; main <= in.
  - ONE, in_fire & ~out_fire -> TWO; skid <= in; main holds.
  - ONE, ~in_fire & out_fire -> EMPTY.
  - TWO, out_fire -> ONE; main <= skid.
  - Any other combination: hold state and all data.
- flush=1: next state is EMPTY and the skid entry is discarded. An out_fire in the same cycle still counts as consumed by downstream. No input is accepted because in_ready=0.
- out_ir = NOP_IR whenever the state is EMPTY, including after a flush.
- out_pc and out_data retain the last main contents when EMPTY; they are not cleared.
- stall_cycles increments every cycle with out_valid & ~out_ready and saturates at 2^CW-1. Flush does not clear it; only reset does.
- reset overrides flush and all handshakes.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N, i.e. one cycle, when the stage was EMPTY or was ONE with out_fire.
- Throughput: one entry per cycle while out_ready=1.
- Backpressure: in_ready falls in the cycle after the stage reaches TWO. The single entry that arrives under the stall is absorbed by the skid entry, so no entry is lost or duplicated.
- TWO to ONE: the skid entry moves to main on the out_fire edge. in_ready rises in the following cycle, which leaves a one-cycle input bubble by design.
- Reset values after the reset edge: state EMPTY, out_valid=0, out_ir=NOP_IR, out_pc=RESET_PC, out_data=0, occupancy=0, stall_cycles=0.
- in_ready=1 after reset unless flush=1. in_valid is ignored while reset=1.
- Reset during TWO with a stall active discards both entries in one edge.

## Test plan
- Reset then stream: in_ir 32'h0000_0001..5, one per cycle, out_ready=1 -> out_ir follows one cycle later; occupancy stays 1; stall_cycles=0.
- Backpressure: stream 8 entries, out_ready=0 for cycles 3-6 -> occupancy reaches 2, in_ready=0 while stalled, stall_cycles=4, all 8 entries delivered in order with none lost or duplicated.
- Flush in TWO: fill to occupancy 2, assert flush with out_ready=0 -> next cycle out_valid=0, out_ir=NOP_IR, occupancy=0, in_ready=1; no skid entry is ever delivered.
- Flush with in_valid=1 and out_fire in the same cycle -> in_ready=0; the output entry is counted as delivered; the input entry is not captured.
- Reset mid-stall: occupancy 2, reset=1 with in_valid=1 -> out_pc=32'h0000_3000, out_data=0, stall_cycles=0, occupancy=0.
- Saturation: CW=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles=15 and holds at 15.
